// File: rtl/boot_copier.sv
// boot_copier: boot sequencer that copies WORDS 32-bit words from SPI flash
// into RAM after reset, holding the CPU in reset until the copy completes.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   defined   -> the last image word is an additive checksum of the others;
//                a mismatch parks the block in ERROR with the CPU held.
//   undefined -> no checksum, error tied low.
//
// Ports:
//   CLK, reset          clock, synchronous active-high reset
//   cpu_reset           CPU reset / bus ownership (high while copying or failed)
//   done, error         sticky completion / checksum failure flags
//   flash_rstrb         one-cycle read strobe to spi_flash
//   flash_word_address  flash word address
//   flash_rdata/rbusy   flash read data / busy
//   ram_addr            RAM byte address ({word, 2'b00})
//   ram_wdata/wmask     RAM write data / byte mask (4'hF for one cycle per word)
module boot_copier #(
    parameter int unsigned WORDS           = 1024,
    parameter logic [14:0] FLASH_BASE_WORD = 15'h0000,
    parameter logic [29:0] RAM_BASE_WORD   = 30'h0
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic        flash_rstrb,
    output logic [14:0] flash_word_address,
    input  logic [31:0] flash_rdata,
    input  logic        flash_rbusy,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask
);

    localparam int unsigned IDX_W      = 15;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RAM_WORD_W = 30;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        ISSUE = 3'd0,
        ARM   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
`ifdef BOOT_CHECKSUM_EN
        ,
        CHECK = 3'd5,
        ERROR = 3'd6
`endif
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [DATA_W-1:0]       data_buf;
    logic [RAM_WORD_W-1:0]   ram_word;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0]       sum;
    logic                    error_q;
`endif

    // Copy sequencer; all status and RAM-side outputs are registered here.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= ISSUE;
            idx       <= '0;
            data_buf  <= '0;
            ram_word  <= RAM_BASE_WORD;
            ram_wmask <= 4'h0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum       <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            case (state)
                // Hold here while a read abandoned by reset is still in flight;
                // the strobe itself is suppressed until the flash is idle.
                ISSUE: begin
                    if (!flash_rbusy) begin
                        state <= ARM;
                    end
                end
                // Flash raises busy one cycle after the strobe, so skip a cycle.
                ARM: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!flash_rbusy) begin
                        data_buf  <= flash_rdata;
                        ram_word  <= RAM_BASE_WORD + RAM_WORD_W'(idx);
                        ram_wmask <= 4'hF;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    ram_wmask <= 4'h0;
                    if (idx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
                        state     <= CHECK;
`else
                        state     <= DONE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ISSUE;
`ifdef BOOT_CHECKSUM_EN
                        sum   <= sum + data_buf;
`endif
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                // Last word carries the expected sum of all earlier words.
                CHECK: begin
                    if (sum == data_buf) begin
                        state     <= DONE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state   <= ERROR;
                        error_q <= 1'b1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
`endif
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= ISSUE;
                end
            endcase
        end
    end

    // Strobe is gated so the flash never sees a request while busy or in reset.
    assign flash_rstrb        = (state == ISSUE) && !reset && !flash_rbusy;
    assign flash_word_address = FLASH_BASE_WORD + idx;
    assign ram_addr           = {ram_word, 2'b00};
    assign ram_wdata          = data_buf;

`ifdef BOOT_CHECKSUM_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: self-checking bench for boot_copier (4-word and 1-word builds)
// with a behavioural flash model and an expected-write scoreboard.
module tb_boot_copier;

    localparam int unsigned N  = 4;
    localparam logic [14:0] FB = 15'd8;
    localparam logic [29:0] RB = 30'h10;
`ifdef BOOT_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic reset = 1'b1;
    logic reset1 = 1'b1;

    logic        cpu_reset, done, error, flash_rstrb, flash_rbusy;
    logic [14:0] flash_word_address;
    logic [31:0] flash_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_wmask;

    logic        cpu_reset1, done1, error1, flash_rstrb1;
    logic [14:0] flash_word_address1;
    logic [31:0] ram_addr1, ram_wdata1;
    logic [3:0]  ram_wmask1;
    logic [31:0] rdata1 = 32'h0;

    boot_copier #(.WORDS(N), .FLASH_BASE_WORD(FB), .RAM_BASE_WORD(RB)) u0 (
        .CLK(CLK), .reset(reset), .cpu_reset(cpu_reset), .done(done), .error(error),
        .flash_rstrb(flash_rstrb), .flash_word_address(flash_word_address),
        .flash_rdata(flash_rdata), .flash_rbusy(flash_rbusy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask));

    boot_copier #(.WORDS(1), .FLASH_BASE_WORD(FB), .RAM_BASE_WORD(RB)) u1 (
        .CLK(CLK), .reset(reset1), .cpu_reset(cpu_reset1), .done(done1), .error(error1),
        .flash_rstrb(flash_rstrb1), .flash_word_address(flash_word_address1),
        .flash_rdata(rdata1), .flash_rbusy(1'b0),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wmask(ram_wmask1));

    int compared = 0;
    int failed   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- flash model: busy for lat cycles starting one cycle after the strobe
    logic [31:0] image [0:15];
    int          age = 0;
    int          cur_lat = 0;
    int          lat_mode = 0;
    logic [14:0] pend_addr = '0;
    int          lat_q[$];
    logic [14:0] strobe_addr_q[$];
    int          strobes = 0;
    logic        ovr = 1'b0;
    logic        ovr_busy = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    logic        m_busy;
    logic [31:0] m_data;

    assign m_busy      = (age >= 2) && (age <= cur_lat + 1);
    assign m_data      = (age >= cur_lat + 2) ? image[pend_addr[3:0]] : 32'hDEAD_BEEF;
    assign flash_rbusy = ovr ? ovr_busy : m_busy;
    assign flash_rdata = ovr ? ovr_data : m_data;

    always @(posedge CLK) begin
        if (flash_rstrb) begin
            int l;
            l = (lat_mode < 0) ? int'($urandom_range(0, 6)) : lat_mode;
            cur_lat   <= l;
            age       <= 1;
            pend_addr <= flash_word_address;
            lat_q.push_back(l);
            strobe_addr_q.push_back(flash_word_address);
            strobes++;
        end else if (age != 0 && age < 1000) begin
            age <= age + 1;
        end
    end

    // ---------------- write scoreboard and strobe-while-busy monitor
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    int  writes = 0;

    always @(negedge CLK) begin
        if (flash_rbusy) begin
            compared++;
            if (flash_rstrb) begin
                failed++;
                $display("FAIL strobe_while_busy: got 1 expected 0");
            end
        end
        if (ram_wmask != 4'h0) begin
            writes++;
            compared++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", ram_addr, ram_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (ram_addr !== e.addr || ram_wdata !== e.data || ram_wmask !== 4'hF) begin
                    failed++;
                    $display("FAIL ram_write: got %0h/%0h/%0h expected %0h/%0h/f",
                             ram_addr, ram_wdata, ram_wmask, e.addr, e.data);
                end
            end
        end
    end

    task automatic fill_exp();
        exp_q.delete();
        for (int i = 0; i < int'(N); i++) begin
            wr_t w;
            w.addr = 32'((32'h10 + i) * 4);
            w.data = image[8 + i];
            exp_q.push_back(w);
        end
    endtask

    task automatic start_run();
        fill_exp();
        lat_q.delete();
        strobe_addr_q.delete();
        strobes = 0;
        writes  = 0;
        ovr     = 1'b0;
        @(negedge CLK) reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rstrb", flash_rstrb, 0);
        check("rst_wmask", ram_wmask, 0);
        check("rst_faddr", flash_word_address, FB);
        reset = 1'b0;
    endtask

    // Counts clock edges after reset release until cpu_reset is seen low.
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(negedge CLK);
            edges++;
        end while (cpu_reset === 1'b1 && edges < 1500);
    endtask

    task automatic check_end(input string nm, input bit exp_err, input int exp_edges, input int edges);
        if (exp_err) begin
            check({nm, "_held"}, edges, 1500);
            check({nm, "_cpu_reset"}, cpu_reset, 1);
            check({nm, "_done"}, done, 0);
            check({nm, "_error"}, error, 1);
        end else begin
            check({nm, "_edges"}, edges, exp_edges);
            check({nm, "_done"}, done, 1);
            check({nm, "_error"}, error, 0);
            check({nm, "_writes"}, writes, N);
            check({nm, "_strobes"}, strobes, N);
            check({nm, "_left"}, exp_q.size(), 0);
        end
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        int          lat;
        int          cyc;       // cycle index of DONE without the checksum stage
        bit          bad_sum;   // image checksum mismatches
    } vec_t;
    vec_t tbl[4];

    task automatic load(input vec_t v);
        for (int k = 0; k < 16; k++) image[k] = 32'hA0 + 32'(k);
        image[8]  = v.w0;
        image[9]  = v.w1;
        image[10] = v.w2;
        image[11] = v.w3;
    endtask

    initial begin
        int edges;
        int s;
        int bad_strb, bad_mask, bad_done, w1cnt;
        logic [31:0] d1;

        tbl[0] = '{w0:32'hA8, w1:32'hA9, w2:32'hAA, w3:32'hAB, lat:0,  cyc:17, bad_sum:1'b1};
        tbl[1] = '{w0:32'hA8, w1:32'hA9, w2:32'hAA, w3:32'hAB, lat:20, cyc:97, bad_sum:1'b1};
        tbl[2] = '{w0:32'd1,  w1:32'd2,  w2:32'd3,  w3:32'd6,  lat:1,  cyc:21, bad_sum:1'b0};
        tbl[3] = '{w0:32'd1,  w1:32'd2,  w2:32'd3,  w3:32'd7,  lat:0,  cyc:17, bad_sum:1'b1};

        for (int t = 0; t < 4; t++) begin
            load(tbl[t]);
            lat_mode = tbl[t].lat;
            start_run();
            wait_done(edges);
            check_end($sformatf("vec%0d", t), (CHK != 0) && tbl[t].bad_sum,
                      tbl[t].cyc - 1 + CHK, edges);
        end

        // Reset pulse during WAIT of word 2 with a long flash read in flight.
        load(tbl[0]);
        lat_mode = 20;
        start_run();
        s = 0;
        while (strobes < 3 && s < 400) begin
            @(negedge CLK);
            s++;
        end
        check("rstwait_reached", strobes, 3);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        fill_exp();
        strobe_addr_q.delete();
        strobes = 0;
        writes  = 0;
        wait_done(edges);
        check("rstwait_done", done, 1);
        check("rstwait_writes", writes, N);
        check("rstwait_strobes", strobes, N);
        check("rstwait_left", exp_q.size(), 0);
        check("rstwait_first_addr", (strobe_addr_q.size() > 0) ? strobe_addr_q[0] : 15'h7FFF, FB);

        // After DONE, flash activity must be ignored.
        ovr = 1'b1;
        bad_strb = 0; bad_mask = 0; bad_done = 0;
        repeat (100) begin
            ovr_busy = 1'($urandom);
            ovr_data = $urandom;
            @(negedge CLK);
            if (flash_rstrb) bad_strb++;
            if (ram_wmask != 4'h0) bad_mask++;
            if (done !== 1'b1) bad_done++;
        end
        check("post_done_strobes", bad_strb, 0);
        check("post_done_wmask", bad_mask, 0);
        check("post_done_done", bad_done, 0);
        ovr = 1'b0;

        // Randomised images and per-read latencies against the cycle model.
        for (int r = 0; r < 8; r++) begin
            bit coin;
            for (int k = 0; k < 16; k++) image[k] = $urandom;
            coin = 1'($urandom);
            if (CHK != 0) image[11] = image[8] + image[9] + image[10] + (coin ? 32'd1 : 32'd0);
            lat_mode = -1;
            start_run();
            wait_done(edges);
            s = 0;
            foreach (lat_q[i]) s += 4 + lat_q[i];
            check_end($sformatf("rand%0d", r), (CHK != 0) && coin, s + CHK, edges);
        end

        // Single-word build.
        d1 = (CHK != 0) ? 32'h0 : 32'h1234_5678;
        rdata1 = d1;
        @(negedge CLK) reset1 = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("w1_rst_cpu_reset", cpu_reset1, 1);
        reset1 = 1'b0;
        edges = 0;
        w1cnt = 0;
        do begin
            @(negedge CLK);
            edges++;
            if (ram_wmask1 != 4'h0) begin
                w1cnt++;
                check("w1_addr", ram_addr1, 32'h40);
                check("w1_data", ram_wdata1, d1);
            end
        end while (done1 !== 1'b1 && edges < 100);
        check("w1_cycle", edges + 1, 5 + CHK);
        check("w1_writes", w1cnt, 1);
        check("w1_cpu_reset", cpu_reset1, 0);
        check("w1_error", error1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/boot_copier.md
# boot_copier

Boot sequencer that owns the memory bus after reset. It copies a fixed image of `WORDS` 32-bit words from the SPI flash into RAM, holding the CPU in reset until the copy is done, then releases it. It sits in `system` between the `spi_flash` read port and the `memory` write port. The system mux gives the bus to this block while `cpu_reset` is high and to the CPU otherwise.

## Interface
Parameters:
- `WORDS`, 1024: number of words copied; legal range 1..32768.
- `FLASH_BASE_WORD`, 15'h0000: first flash word address; `FLASH_BASE_WORD + WORDS` ≤ 32768.
- `RAM_BASE_WORD`, 30'h0: first RAM word address; must decode to RAM, i.e. bits [21:20] = 2'b00.

Ports:
- `CLK` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cpu_reset` out 1: held high while copying (or in error); drives the CPU reset and the bus-ownership mux.
- `done` out 1: copy finished; sticky until `reset`.
- `error` out 1: checksum mismatch; sticky; constant 0 when `BOOT_CHECKSUM_EN` is undefined.
- `flash_rstrb` out 1: one-cycle read strobe to `spi_flash`.
- `flash_word_address` out 15: flash word address.
- `flash_rdata` in 32: flash read data.
- `flash_rbusy` in 1: flash busy.
- `ram_addr` out 32: RAM byte address, equal to `{word_addr, 2'b00}`.
- `ram_wdata` out 32: RAM write data.
- `ram_wmask` out 4: RAM byte write mask; 4'hF for one cycle per word, otherwise 0.

## Operation
- State machine states: ISSUE, ARM, WAIT, WRITE, CHECK (macro only), DONE, ERROR.
- Word counter `idx` is 15 bits wide, reset to 0.
- Data register `buf` is 32 bits wide.
- ISSUE:
  - `flash_rstrb` = 1.
  - `flash_word_address` = `FLASH_BASE_WORD + idx`.
  - Next state: ARM.
- ARM: guard cycle. `flash_rbusy` is ignored here because `spi_flash` raises it one cycle after the strobe. Next state: WAIT.
- WAIT:
  - While `flash_rbusy` = 1, stay in WAIT.
  - On the first cycle with `flash_rbusy` = 0, capture `buf <= flash_rdata` and go to WRITE.
- WRITE:
  - `ram_wmask` = 4'hF.
  - `ram_addr` = `(RAM_BASE_WORD + idx) << 2`.
  - `ram_wdata` = `buf`.
  - If `idx == WORDS-1`: go to DONE, or to CHECK when the macro is defined.
  - Otherwise: `idx <= idx + 1`, go to ISSUE.
- DONE:
  - `cpu_reset` = 0, `done` = 1.
  - Terminal state; only `reset` leaves it.
- ERROR:
  - `cpu_reset` = 1, `error` = 1, `done` = 0.
  - Terminal state; only `reset` leaves it.
- Outputs are Moore, decoded from state and registers:
  - `flash_rstrb` is high only in ISSUE.
  - `ram_wmask` is nonzero only in WRITE.
- Address arithmetic:
  - Flash address is computed modulo 2^15; RAM word address modulo 2^30.
  - Parameter limits guarantee no wrap. Wrap behaviour is therefore unspecified and not verified.
- Reset behaviour:
  - `reset` takes priority in every state.
  - On `reset`: state ← ISSUE, `idx` ← 0, checksum ← 0, `cpu_reset` = 1, `done` = 0, `error` = 0, `flash_rstrb` = 0, `ram_wmask` = 0.
  - A reset during WAIT abandons the pending flash read. The next ISSUE is delayed until `flash_rbusy` = 0, so the flash never sees a strobe while busy.

## Timing
- The first `flash_rstrb` occurs in the first cycle after `reset` deasserts.
- Cycles per word = 3 + B, where B (≥ 1) is the number of WAIT cycles, counting the capture cycle.
- Cycles from `reset` deassertion to `cpu_reset` = 0 = Σ(3 + B_i) + 1 (the +1 is the DONE entry cycle).
- Add 1 cycle for CHECK when the macro is defined.
- With a flash that returns data in the first WAIT cycle, one word takes 4 cycles.
- `done` rises in the same cycle that `cpu_reset` falls.
- RAM writes are one cycle per word, in increasing address order, with no gaps between them.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - A 32-bit accumulator sums `buf` in every WRITE except the last, modulo 2^32.
  - The last word is still written to RAM; it is the expected checksum.
  - The CHECK state compares the sum to the last word: equal → DONE, unequal → ERROR.
  - `WORDS` = 1 compares a sum of 0 against the single word.
- `BOOT_CHECKSUM_EN` undefined:
  - No accumulator, no CHECK state, no ERROR state.
  - `error` is tied to 0 and the last WRITE goes directly to DONE.

## Test plan
- `WORDS`=4, `FLASH_BASE_WORD`=8, `RAM_BASE_WORD`=0x10; flash model with B=1 returning 0xA0+addr → 4 writes to `ram_addr` 0x40, 0x44, 0x48, 0x4C with data 0xA8..0xAB; `cpu_reset` falls exactly 17 cycles after `reset` deasserts.
- Same setup, flash busy for 20 cycles per read → only one strobe per word; `ram_wmask` stays 0 throughout WAIT; `ram_wdata` equals the value sampled on the `flash_rbusy` falling edge.
- `reset` asserted for one cycle during WAIT of word 2 → `idx` restarts at 0; no `flash_rstrb` while `flash_rbusy`=1; the full 4-word copy then completes.
- With `BOOT_CHECKSUM_EN`, image {1, 2, 3, 6} → DONE, `error`=0. Image {1, 2, 3, 7} → ERROR, `error`=1, `cpu_reset` remains 1 for 1000 cycles, `done`=0.
- `WORDS`=1, flash word = 0x12345678, macro off → a single write, then `done`=1 after 5 cycles. Macro on, flash word = 0 → DONE after 6 cycles.
- After DONE, toggle `flash_rbusy` and `flash_rdata` for 100 cycles → no `flash_rstrb`, `ram_wmask`=0, `done` stays 1.
